slim_anim_ctrl: RTL

SLIM_ANIM_CTRL -- requirements
Module: slim_anim_ctrl

---
 rtl/slim_pkg.sv | 32 +++
 rtl/slim_addr_gen.sv | 44 ++++
 rtl/slim_anim_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/slim_pkg.sv
// Shared definitions for the slime animation controller: sprite defaults,
// FSM state encoding (value doubles as freeze level) and sprite ROM select codes.
package slim_pkg;

   localparam int unsigned SprWDefault = 34;
   localparam int unsigned SprHDefault = 33;

   typedef enum logic [1:0] {
      StWalk = 2'd0,
      StF1   = 2'd1,
      StF2   = 2'd2,
      StBall = 2'd3
   } state_e;

   localparam logic [2:0] SelWalk1   = 3'd0;
   localparam logic [2:0] SelWalk3   = 3'd1;
   localparam logic [2:0] SelWalk7   = 3'd2;
   localparam logic [2:0] SelFrozen1 = 3'd3;
   localparam logic [2:0] SelFrozen3 = 3'd4;
   localparam logic [2:0] SelFrozen9 = 3'd5;

   // Walk cycle spends 2 phases on walk1, 4 on walk3 and the remaining 10 on walk7.
   function automatic logic [2:0] walk_sel(input logic [3:0] phase);
      if (phase < 4'd2) begin
         return SelWalk1;
      end else if (phase < 4'd6) begin
         return SelWalk3;
      end
      return SelWalk7;
   endfunction

endpackage

// File: rtl/slim_addr_gen.sv
// Sprite ROM address generator: registered bounds check and row-major address.
// Horizontal mirroring on dir=1 is built only when SLIM_MIRROR_EN is defined.
module slim_addr_gen
   import slim_pkg::*;
#(
   parameter int unsigned SPR_W = SprWDefault,
   parameter int unsigned SPR_H = SprHDefault
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dir,
   input  logic [5:0]  pix_x,
   input  logic [5:0]  pix_y,
   output logic [13:0] rom_addr,
   output logic        pix_valid
);

   logic        valid_c;
   logic [13:0] col_c;
   logic [13:0] addr_c;

   assign valid_c = ({26'd0, pix_x} < SPR_W) && ({26'd0, pix_y} < SPR_H);

`ifdef SLIM_MIRROR_EN
   assign col_c = dir ? (14'(SPR_W - 1) - {8'd0, pix_x}) : {8'd0, pix_x};
`else
   logic unused_dir;
   assign unused_dir = dir;
   assign col_c      = {8'd0, pix_x};
`endif

   assign addr_c = ({8'd0, pix_y} * 14'(SPR_W)) + col_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         rom_addr  <= '0;
         pix_valid <= 1'b0;
      end else begin
         rom_addr  <= valid_c ? addr_c : '0;
         pix_valid <= valid_c;
      end
   end

endmodule

// File: rtl/slim_anim_ctrl.sv
// Slime sprite animation controller: walk phase, freeze/thaw FSM and ROM select.
// Build with SLIM_MIRROR_EN to mirror the sprite horizontally when facing right.
module slim_anim_ctrl
   import slim_pkg::*;
#(
   parameter int unsigned SPR_W      = SprWDefault,
   parameter int unsigned SPR_H      = SprHDefault,
   parameter int unsigned THAW_TICKS = 120
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        move_en,
   input  logic        dir,
   input  logic        hit,
   input  logic [5:0]  pix_x,
   input  logic [5:0]  pix_y,
   output logic [2:0]  rom_sel,
   output logic [13:0] rom_addr,
   output logic        pix_valid,
   output logic [1:0]  frz_lvl,
   output logic        thaw_evt
);

   localparam int unsigned TimerW = (THAW_TICKS > 1) ? $clog2(THAW_TICKS) : 1;
   localparam logic [TimerW-1:0] TimerReload = TimerW'(THAW_TICKS - 1);

   state_e            state_q, state_d;
   logic [3:0]        phase_q, phase_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [2:0]        sel_q, sel_d;
   logic              thaw_q, thaw_d;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      timer_d = timer_q;
      thaw_d  = 1'b0;
      // A hit always wins over a simultaneous thaw expiry.
      if (hit) begin
         timer_d = TimerReload;
         unique case (state_q)
            StWalk:  state_d = StF1;
            StF1:    state_d = StF2;
            StF2:    state_d = StBall;
            StBall:  state_d = StBall;
            default: state_d = StWalk;
         endcase
      end else if (frame_tick) begin
         if (state_q == StWalk) begin
            if (move_en) begin
               phase_d = phase_q + 4'd1;
            end
         end else if (timer_q == '0) begin
            thaw_d  = 1'b1;
            timer_d = TimerReload;
            unique case (state_q)
               StBall:  state_d = StF2;
               StF2:    state_d = StF1;
               default: begin
                  state_d = StWalk;
                  phase_d = 4'd0;
               end
            endcase
         end else begin
            timer_d = timer_q - TimerW'(1);
         end
      end
   end

   always_comb begin
      sel_d = SelWalk1;
      unique case (state_d)
         StWalk: sel_d = walk_sel(phase_d);
         StF1:   sel_d = SelFrozen1;
         StF2:   sel_d = SelFrozen3;
         StBall: sel_d = SelFrozen9;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StWalk;
         phase_q <= 4'd0;
         timer_q <= TimerReload;
         sel_q   <= SelWalk1;
         thaw_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         timer_q <= timer_d;
         sel_q   <= sel_d;
         thaw_q  <= thaw_d;
      end
   end

   assign rom_sel  = sel_q;
   assign frz_lvl  = state_q;
   assign thaw_evt = thaw_q;

   slim_addr_gen #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H)
   ) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .dir       (dir),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .rom_addr  (rom_addr),
      .pix_valid (pix_valid)
   );

endmodule
